// File: rtl/hex_share_arbiter.sv
// hex_share_arbiter: round-robin sharing of one 7-segment decoder among four requesters
module hex_share_arbiter #(
  parameter int unsigned HOLD_CYCLES = 3
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [3:0]  req,
  input  logic [15:0] value,
  output logic [3:0]  dec_in,
  input  logic [6:0]  dec_seg,
  output logic [3:0]  grant,
  output logic [3:0]  done,
  output logic [27:0] seg_out,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE} state_t;
  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d, win_q, win_d, pick, idx;
  logic [3:0]  cnt_q, cnt_d, grant_q, grant_d, done_q, done_d, dec_in_q, dec_in_d;
  logic [27:0] seg_q, seg_d;
  logic        busy_q, busy_d;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      cnt_q    <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      dec_in_q <= '0;
      seg_q    <= '1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      dec_in_q <= dec_in_d;
      seg_q    <= seg_d;
      busy_q   <= busy_d;
    end
  end
  always_comb begin
    state_d = (state_q == IDLE)  ? ((|req) ? DRIVE : IDLE) :
              (state_q == DRIVE) ? ((cnt_q == 4'd0) ? CAPTURE : DRIVE) : IDLE;
    busy_d  = (state_d != IDLE);
  end
  // Walk offsets high to low so the smallest offset from ptr wins.
  always_comb begin
    pick = ptr_q;
    idx  = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr_q + 2'(i);
      if (req[idx]) pick = idx;
    end
  end
  always_comb begin
    ptr_d    = ptr_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    done_d   = 4'b0000;
    dec_in_d = dec_in_q;
    seg_d    = seg_q;
    if (state_q == IDLE && (|req)) begin
      win_d    = pick;
      grant_d  = 4'b0001 << pick;
      dec_in_d = value[4*pick +: 4];
      cnt_d    = 4'(HOLD_CYCLES - 1);
    end
    if (state_q == DRIVE) begin
      cnt_d = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
      if (cnt_q == 4'd0) begin
        seg_d[7*win_q +: 7] = dec_seg;
        done_d              = grant_q;
      end
    end
    if (state_q == CAPTURE) begin
      grant_d = 4'b0000;
      ptr_d   = win_q + 2'd1;
    end
  end
  assign dec_in  = dec_in_q;
  assign grant   = grant_q;
  assign done    = done_q;
  assign seg_out = seg_q;
  assign busy    = busy_q;
endmodule

// File: tb/tb_hex_share_arbiter.sv
// tb_hex_share_arbiter: scoreboard bench; expected captures queued at stimulus, checked on done.
module tb_hex_share_arbiter;
  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dec_in, grant, done;
  logic [6:0]  dec_seg;
  logic [27:0] seg_out;
  logic        busy;
  typedef struct packed {logic [1:0] idx; logic [6:0] seg;} exp_t;
  exp_t        sb[$];
  exp_t        e;
  logic [27:0] seg_model;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [6:0] hex7(input logic [3:0] d);
    case (d)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign dec_seg = hex7(dec_in);

  hex_share_arbiter #(.HOLD_CYCLES(3)) dut (
    .clock(clock), .resetn(resetn), .req(req), .value(value), .dec_in(dec_in),
    .dec_seg(dec_seg), .grant(grant), .done(done), .seg_out(seg_out), .busy(busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock or negedge resetn) begin
    if (!resetn) seg_model = '1;
    else if (done != 4'b0000) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_done got=%b expected none", done);
      end else begin
        e = sb.pop_front();
        seg_model[7*e.idx +: 7] = e.seg;
        if (done !== (4'b0001 << e.idx)) begin
          n_bad++;
          $display("FAIL done_winner got=%b expected=%b", done, 4'b0001 << e.idx);
        end
        n_cmp++;
        if (seg_out !== seg_model) begin
          n_bad++;
          $display("FAIL seg_capture got=%h expected=%h", seg_out, seg_model);
        end
      end
    end
  end

  task automatic do_reset;
    resetn = 1'b0;
    req    = 4'b0000;
    value  = 16'h0000;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    req    = 4'b1111;
    value  = 16'hFFFF;
    repeat (3) @(negedge clock);
    n_cmp += 5;
    if (grant !== 4'b0000) begin n_bad++; $display("FAIL reset_grant got=%b expected=0000", grant); end
    if (done !== 4'b0000) begin n_bad++; $display("FAIL reset_done got=%b expected=0000", done); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b expected=0", busy); end
    if (dec_in !== 4'h0) begin n_bad++; $display("FAIL reset_dec_in got=%h expected=0", dec_in); end
    if (seg_out !== {28{1'b1}}) begin n_bad++; $display("FAIL reset_seg got=%h expected=fffffff", seg_out); end
    do_reset();
  endtask

  task automatic test_single;
    logic [3:0] eg, ed;
    do_reset();
    value = 16'h0001;
    req   = 4'b0001;
    sb.push_back('{idx: 2'd0, seg: hex7(4'h1)});
    @(negedge clock);
    req = 4'b0000;
    for (int c = 1; c <= 5; c++) begin
      eg = (c <= 4) ? 4'b0001 : 4'b0000;
      ed = (c == 4) ? 4'b0001 : 4'b0000;
      n_cmp += 2;
      if (grant !== eg) begin n_bad++; $display("FAIL single_grant c=%0d got=%b expected=%b", c, grant, eg); end
      if (done !== ed) begin n_bad++; $display("FAIL single_done c=%0d got=%b expected=%b", c, done, ed); end
      if (c == 4) begin
        n_cmp += 2;
        if (seg_out[6:0] !== 7'b1111001) begin n_bad++; $display("FAIL single_slot0 got=%b expected=1111001", seg_out[6:0]); end
        if (seg_out[27:7] !== {21{1'b1}}) begin n_bad++; $display("FAIL single_others got=%h expected=all ones", seg_out[27:7]); end
      end
      if (c < 5) @(negedge clock);
    end
    n_cmp += 2;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_end got=%b expected=0", busy); end
    if (sb.size() != 0) begin n_bad++; $display("FAIL single_pending got=%0d expected=0", sb.size()); end
  endtask

  task automatic test_round_robin;
    logic [3:0] eg, ed;
    int s, p;
    do_reset();
    value = 16'h8421;
    req   = 4'b1111;
    sb.push_back('{idx: 2'd0, seg: hex7(4'h1)});
    sb.push_back('{idx: 2'd1, seg: hex7(4'h2)});
    sb.push_back('{idx: 2'd2, seg: hex7(4'h4)});
    sb.push_back('{idx: 2'd3, seg: hex7(4'h8)});
    sb.push_back('{idx: 2'd0, seg: hex7(4'h1)});
    @(negedge clock);
    for (int c = 0; c < 25; c++) begin
      s  = c / 5;
      p  = c % 5;
      eg = (p < 4) ? 4'(1 << (s % 4)) : 4'b0000;
      ed = (p == 3) ? eg : 4'b0000;
      n_cmp += 2;
      if (grant !== eg) begin n_bad++; $display("FAIL rr_grant c=%0d got=%b expected=%b", c, grant, eg); end
      if (done !== ed) begin n_bad++; $display("FAIL rr_done c=%0d got=%b expected=%b", c, done, ed); end
      if (c == 23) req = 4'b0000;
      if (c < 24) @(negedge clock);
    end
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL rr_pending got=%0d expected=0", sb.size()); end
  endtask

  task automatic test_stability;
    do_reset();
    value = 16'h0020;
    req   = 4'b0010;
    sb.push_back('{idx: 2'd1, seg: 7'b0100100});
    @(negedge clock);
    req   = 4'b0000;
    value = 16'h00F0;
    for (int c = 1; c <= 4; c++) begin
      n_cmp += 2;
      if (dec_in !== 4'h2) begin n_bad++; $display("FAIL stab_dec_in c=%0d got=%h expected=2", c, dec_in); end
      if (grant !== 4'b0010) begin n_bad++; $display("FAIL stab_grant c=%0d got=%b expected=0010", c, grant); end
      if (c < 4) @(negedge clock);
    end
    @(negedge clock);
    n_cmp += 2;
    if (seg_out[13:7] !== 7'b0100100) begin n_bad++; $display("FAIL stab_slot1 got=%b expected=0100100", seg_out[13:7]); end
    if (sb.size() != 0) begin n_bad++; $display("FAIL stab_pending got=%0d expected=0", sb.size()); end
  endtask

  task automatic test_withdrawal;
    logic [3:0] ed;
    do_reset();
    value = 16'h0400;
    req   = 4'b0100;
    sb.push_back('{idx: 2'd2, seg: hex7(4'h4)});
    @(negedge clock);
    req = 4'b0000;
    for (int c = 1; c <= 5; c++) begin
      ed = (c == 4) ? 4'b0100 : 4'b0000;
      n_cmp += 2;
      if (busy !== (c <= 4)) begin n_bad++; $display("FAIL wd_busy c=%0d got=%b expected=%b", c, busy, c <= 4); end
      if (done !== ed) begin n_bad++; $display("FAIL wd_done c=%0d got=%b expected=%b", c, done, ed); end
      if (c < 5) @(negedge clock);
    end
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL wd_pending got=%0d expected=0", sb.size()); end
  endtask

  task automatic test_abort;
    do_reset();
    value = 16'h500A;
    req   = 4'b1000;
    @(negedge clock);
    n_cmp++;
    if (grant !== 4'b1000) begin n_bad++; $display("FAIL abort_pre_grant got=%b expected=1000", grant); end
    req = 4'b0000;
    @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    n_cmp += 3;
    if (done !== 4'b0000) begin n_bad++; $display("FAIL abort_done got=%b expected=0000", done); end
    if (grant !== 4'b0000) begin n_bad++; $display("FAIL abort_grant got=%b expected=0000", grant); end
    if (seg_out[27:21] !== 7'b1111111) begin n_bad++; $display("FAIL abort_slot3 got=%b expected=1111111", seg_out[27:21]); end
    resetn = 1'b1;
    req    = 4'b1001;
    sb.push_back('{idx: 2'd0, seg: hex7(4'hA)});
    sb.push_back('{idx: 2'd3, seg: hex7(4'h5)});
    @(negedge clock);
    n_cmp++;
    if (grant !== 4'b0001) begin n_bad++; $display("FAIL abort_first_grant got=%b expected=0001", grant); end
    repeat (5) @(negedge clock);
    n_cmp++;
    if (grant !== 4'b1000) begin n_bad++; $display("FAIL abort_second_grant got=%b expected=1000", grant); end
    req = 4'b0000;
    repeat (4) @(negedge clock);
    n_cmp += 2;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy_end got=%b expected=0", busy); end
    if (sb.size() != 0) begin n_bad++; $display("FAIL abort_pending got=%0d expected=0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stability();
    test_withdrawal();
    test_abort();
    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hex_share_arbiter.md
HEX_SHARE_ARBITER -- requirements
Module: hex_share_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 3, number of cycles the shared decoder input is held stable before segment capture; legal range 1..15.
REQ-002 clock  input  1  single rising-edge clock for all state.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 req  input  4  request from requester i on bit i, level-sensitive.
REQ-005 value  input  16  4-bit hex digit of requester i on value[4i+3:4i].
REQ-006 dec_in  output  4  digit driven to the shared 7-segment decoder (registered).
REQ-007 dec_seg  input  7  active-low segment pattern returned by the shared decoder, combinational from dec_in.
REQ-008 grant  output  4  one-hot, requester currently owning the decoder; all-zero when idle.
REQ-009 done  output  4  one-cycle pulse on bit i when requester i's result is valid.
REQ-010 seg_out  output  28  latched segment pattern of requester i on seg_out[7i+6:7i].
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 FSM states IDLE, DRIVE, CAPTURE; all outputs registered.
REQ-013 IDLE: if req != 0 at a rising edge, select winner by round-robin starting at pointer ptr (2 bits), searching ptr, ptr+1, ptr+2, ptr+3 mod 4; else remain IDLE with grant = 0.
REQ-014 On the selecting edge: grant <= one-hot(winner), dec_in <= value of winner, hold counter <= HOLD_CYCLES-1, state <= DRIVE.
REQ-015 DRIVE lasts exactly HOLD_CYCLES cycles; counter decrements each cycle; the edge at which the counter equals 0 latches dec_seg into seg_out slot of winner and moves to CAPTURE.
REQ-016 CAPTURE lasts one cycle: done[winner] = 1, grant still = one-hot(winner), seg_out slot already updated; next edge: grant <= 0, ptr <= winner+1 mod 4, state <= IDLE.
REQ-017 Latency: req sampled at edge k -> grant high cycles k+1..k+HOLD_CYCLES+1, done high in cycle k+HOLD_CYCLES+1; minimum service period HOLD_CYCLES+2 cycles.
REQ-018 dec_in and winner frozen for the whole service; changes to value or req during DRIVE/CAPTURE are ignored.
REQ-019 req withdrawn mid-service: service still completes, done still pulses, seg_out still updated.
REQ-020 Fairness: with multiple continuous requesters, no requester is served twice before every other requester that was requesting at the time has been served.
REQ-021 Only the winner's seg_out slot changes; other slots hold.
REQ-022 done is zero in IDLE and DRIVE; at most one done bit high at any time; grant is always zero or one-hot.

Reset
REQ-023 resetn low asynchronously forces: state IDLE, ptr 0, counter 0, grant 4'b0000, done 4'b0000, busy 0, dec_in 4'h0, every seg_out slot 7'b1111111 (all segments off).
REQ-024 resetn asserted mid-service aborts it: no done pulse, no seg_out update; first arbitration after release starts at ptr 0.

Verification (HOLD_CYCLES = 3, bench decoder model standard active-low hex)
REQ-025 Reset: resetn low with req = 4'b1111 -> grant 0, done 0, busy 0, dec_in 0, seg_out = 28 ones.
REQ-026 Single request: req = 4'b0001, value[3:0] = 4'h1 sampled at edge k -> grant 4'b0001 cycles k+1..k+4, done[0] in cycle k+4, seg_out[6:0] = 7'b1111001, others still 7'b1111111.
REQ-027 Round-robin: req = 4'b1111 held, value = 16'h8421 -> grant sequence 0001, 0010, 0100, 1000, 0001, one IDLE cycle between services, each slot receives its digit's pattern.
REQ-028 Stability: value[7:4] changed from 4'h2 to 4'hF during requester 1's DRIVE -> dec_in stays 4'h2, seg_out[13:7] = 7'b0100100.
REQ-029 Withdrawal: req[2] pulsed for one cycle only -> full service, done[2] pulses, busy returns to 0 after CAPTURE.
REQ-030 Abort: resetn low for one cycle during DRIVE of requester 3 -> no done[3], seg_out[27:21] = 7'b1111111, next service with req = 4'b1001 grants requester 0 first.
